regdec_left_ctrl: RTL and testbench
===================================

Name: regdec_left_ctrl

Overview:
Sequencing controller for the 8-bit left-shift register (sequential_regdec_left). It accepts a load+shift request over a valid/ready handshake and drives the register's 3-bit sequencer code, parallel data and serial fill bit. It reads back the register output and returns the shifted word with a one-cycle done pulse. It sits between the datapath requester and the shift register, which it owns exclusively.

Parameters:
WIDTH, 8, data width of the controlled register
SHW, 3, width of shift-amount field (max shift 2^SHW-1 = 7)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request valid
ready  output  1  high only in IDLE; request accepted on edge where start&ready
data_in  input  WIDTH  word to load
shamt  input  SHW  number of single-bit left shifts
fill  input  1  serial bit shifted into LSB on each shift
abort  input  1  cancel in-flight operation
seq  output  3  sequencer code to register: 0 hold, 1 load reg_d, 2 shift left one, 3 clear
reg_d  output  WIDTH  parallel load data to register
serial_in  output  1  LSB fill bit to register
reg_q  input  WIDTH  register output, fed back
result  output  WIDTH  captured shifted word
done  output  1  one-cycle pulse, result valid
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, LOAD, SHIFT, CAPT, CLR.
- Reset (synchronous, wins over everything, any state): state=IDLE; seq=0, reg_d=0, serial_in=0, result=0, done=0, busy=0, ready=1. Shift counter=0.
- IDLE: seq=0. On start&ready, latch data_in, shamt and fill. Next state is LOAD.
- LOAD, one cycle: seq=1, reg_d=latched data. Next state is SHIFT if shamt!=0, else CAPT.
- SHIFT: seq=2, serial_in=latched fill, for exactly shamt cycles. Counter counts down; leave for CAPT when it reaches 1.
- CAPT, one cycle: seq=0. At the closing edge, result<=reg_q and done<=1. Next state is IDLE.
- done is high for exactly one cycle, the first IDLE cycle after CAPT. A start in that cycle is accepted.
- Latency: accept edge at cycle 0; done is high in cycle shamt+3. Throughput is one op per shamt+3 cycles.
- start while busy is ignored. No queuing; latched values are unaffected.
- abort in LOAD or SHIFT goes to CLR. CLR is one cycle with seq=3, then IDLE. No done, result is unchanged.
- abort in IDLE or CAPT is ignored; CAPT completes normally.
- abort and reset together: reset wins.
- reg_d holds the latched data outside LOAD; it is don't-care for the register but must be deterministic.
- seq is a registered output. The register sees the code on the same edge that state advances; no combinational path from start to seq.

Optional Feature:
Macro: REGDEC_CTRL_ROTATE_EN.
- Defined: adds an input port rotate (1 bit), latched at accept. If the latched rotate=1, serial_in=reg_q[WIDTH-1] in SHIFT (rotate left) and fill is ignored. If the latched rotate=0, behaviour is as without the macro.
- Undefined: no rotate port; serial_in is always the latched fill.

Test Plan:
1. Reset held 2 cycles, then released -> seq=0, result=0x00, done=0, ready=1, busy=0.
2. start with data_in=0x7F, shamt=1, fill=0 -> seq 1 in cycle 1, seq 2 in cycle 2, seq 0 in cycle 3; done in cycle 4 with result=0xFE.
3. start with data_in=0x7F, shamt=0 -> LOAD then CAPT; done in cycle 3 with result=0x7F; no seq=2 cycle is ever issued.
4. start with data_in=0x81, shamt=3, fill=1 -> three seq=2 cycles; done in cycle 6 with result=0x0F. A second start (data 0x55) pulsed during SHIFT is ignored.
5. start with data_in=0xAA, shamt=7; abort in the 2nd SHIFT cycle -> one seq=3 cycle, then IDLE. No done; result keeps its previous value 0x0F.
6. (REGDEC_CTRL_ROTATE_EN) data_in=0x81, shamt=1, rotate=1, fill=0 -> result=0x03. Same request with rotate=0 -> result=0x02.

Source files
------------

// File: rtl/regdec_left_ctrl.sv
// Load/shift sequencer for the 8-bit left-shift register, with done pulse.
// Optional REGDEC_CTRL_ROTATE_EN adds a rotate input (MSB feeds the LSB).
module regdec_left_ctrl #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             fill,
`ifdef REGDEC_CTRL_ROTATE_EN
    input  logic             rotate,
`endif
    input  logic             abort,
    output logic [2:0]       seq,
    output logic [WIDTH-1:0] reg_d,
    output logic             serial_in,
    input  logic [WIDTH-1:0] reg_q,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPT,
        S_CLR
    } state_t;

    localparam logic [2:0] SEQ_HOLD  = 3'd0;
    localparam logic [2:0] SEQ_LOAD  = 3'd1;
    localparam logic [2:0] SEQ_SHIFT = 3'd2;
    localparam logic [2:0] SEQ_CLR   = 3'd3;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       seq_q, seq_d;
    logic [WIDTH-1:0] data_q;
    logic             fill_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             accept;
`ifdef REGDEC_CTRL_ROTATE_EN
    logic             rot_q;
`endif

    assign accept = start && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                    cnt_d   = shamt;
                end
            end
            S_LOAD: begin
                if (abort)
                    state_d = S_CLR;
                else if (cnt_q != '0)
                    state_d = S_SHIFT;
                else
                    state_d = S_CAPT;
            end
            S_SHIFT: begin
                if (abort)
                    state_d = S_CLR;
                else if (cnt_q <= SHW'(1))
                    state_d = S_CAPT;
                else
                    cnt_d = cnt_q - SHW'(1);
            end
            S_CAPT:  state_d = S_IDLE;
            S_CLR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Code is decoded from the next state so the register sees it
    // in the same cycle the controller enters that state.
    always_comb begin
        seq_d = SEQ_HOLD;
        unique case (1'b1)
            (state_d == S_LOAD):  seq_d = SEQ_LOAD;
            (state_d == S_SHIFT): seq_d = SEQ_SHIFT;
            (state_d == S_CLR):   seq_d = SEQ_CLR;
            default:              seq_d = SEQ_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            seq_q    <= SEQ_HOLD;
            data_q   <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef REGDEC_CTRL_ROTATE_EN
            rot_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            done_q  <= (state_q == S_CAPT);
            if (state_q == S_CAPT)
                result_q <= reg_q;
            if (accept) begin
                data_q <= data_in;
                fill_q <= fill;
`ifdef REGDEC_CTRL_ROTATE_EN
                rot_q  <= rotate;
`endif
            end
        end
    end

`ifdef REGDEC_CTRL_ROTATE_EN
    assign serial_in = (rot_q && state_q == S_SHIFT)
                     ? reg_q[WIDTH-1] : fill_q;
`else
    assign serial_in = fill_q;
`endif

    assign seq    = seq_q;
    assign reg_d  = data_q;
    assign result = result_q;
    assign done   = done_q;
    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_regdec_left_ctrl.sv
// Directed bench for regdec_left_ctrl with a behavioural shift register.
// Rotate cases run only when REGDEC_CTRL_ROTATE_EN is defined.
module tb_regdec_left_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       ready;
    logic [7:0] data_in;
    logic [2:0] shamt;
    logic       fill;
    logic       abort;
    logic [2:0] seq;
    logic [7:0] reg_d;
    logic       serial_in;
    logic [7:0] reg_q;
    logic [7:0] result;
    logic       done;
    logic       busy;
`ifdef REGDEC_CTRL_ROTATE_EN
    logic       rotate;
`endif

    int tests;
    int failed;

    logic [2:0] seq_log  [0:20];
    logic       busy_log [0:20];
    int         n_done;
    int         done_cyc;
    logic [7:0] res_at_done;

    regdec_left_ctrl #(.WIDTH(8), .SHW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ready     (ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .fill      (fill),
`ifdef REGDEC_CTRL_ROTATE_EN
        .rotate    (rotate),
`endif
        .abort     (abort),
        .seq       (seq),
        .reg_d     (reg_d),
        .serial_in (serial_in),
        .reg_q     (reg_q),
        .result    (result),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The controlled shift register.
    always_ff @(posedge clk) begin
        if (reset)
            reg_q <= 8'h00;
        else begin
            case (seq)
                3'd1:    reg_q <= reg_d;
                3'd2:    reg_q <= {reg_q[6:0], serial_in};
                3'd3:    reg_q <= 8'h00;
                default: reg_q <= reg_q;
            endcase
        end
    end

    // Caller is #1 after an edge with ready high; that next edge accepts.
    // Index k of the logs is cycle k after the accept edge.
    task automatic run_op(input logic [7:0] d, input logic [2:0] sh,
                          input logic f, input logic r,
                          input int abort_at, input int dup_at);
        start   = 1'b1;
        data_in = d;
        shamt   = sh;
        fill    = f;
        abort   = 1'b0;
`ifdef REGDEC_CTRL_ROTATE_EN
        rotate  = r;
`else
        if (r) $display("[TB] note: rotate ignored in this build");
`endif
        n_done      = 0;
        done_cyc    = 0;
        res_at_done = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            seq_log[k]  = seq;
            busy_log[k] = busy;
            if (done) begin
                n_done++;
                done_cyc    = k;
                res_at_done = result;
            end
            start = (k == dup_at);
            if (k == dup_at) begin
                data_in = 8'h55;
                shamt   = 3'd0;
                fill    = ~f;
            end
            abort = (k == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        data_in = 8'h00;
        shamt   = 3'd0;
        fill    = 1'b0;
`ifdef REGDEC_CTRL_ROTATE_EN
        rotate  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (seq !== 3'd0) begin
            failed++;
            $display("FAIL reset_seq got %0d exp 0", seq);
        end
        tests++;
        if (result !== 8'h00) begin
            failed++;
            $display("FAIL reset_result got %h exp 00", result);
        end
        tests++;
        if (done !== 1'b0) begin
            failed++;
            $display("FAIL reset_done got %b exp 0", done);
        end
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_rdy_busy got %b%b exp 10", ready, busy);
        end
        tests++;
        if (serial_in !== 1'b0 || reg_d !== 8'h00) begin
            failed++;
            $display("FAIL reset_outs got %b/%h exp 0/00", serial_in, reg_d);
        end
    endtask

    task automatic test_shift1();
        run_op(8'h7F, 3'd1, 1'b0, 1'b0, 0, 0);
        tests++;
        if (seq_log[1] !== 3'd1 || seq_log[2] !== 3'd2 || seq_log[3] !== 3'd0) begin
            failed++;
            $display("FAIL s1_seq got %0d%0d%0d exp 120",
                     seq_log[1], seq_log[2], seq_log[3]);
        end
        tests++;
        if (done_cyc !== 4 || n_done !== 1) begin
            failed++;
            $display("FAIL s1_done got cyc %0d n %0d exp cyc 4 n 1",
                     done_cyc, n_done);
        end
        tests++;
        if (res_at_done !== 8'hFE) begin
            failed++;
            $display("FAIL s1_result got %h exp fe", res_at_done);
        end
        tests++;
        if (busy_log[1] !== 1'b1 || busy_log[4] !== 1'b0) begin
            failed++;
            $display("FAIL s1_busy got %b%b exp 10", busy_log[1], busy_log[4]);
        end
    endtask

    task automatic test_shift0();
        int n2;
        run_op(8'h7F, 3'd0, 1'b1, 1'b0, 0, 0);
        n2 = 0;
        for (int k = 1; k <= 20; k++)
            if (seq_log[k] === 3'd2) n2++;
        tests++;
        if (seq_log[1] !== 3'd1 || seq_log[2] !== 3'd0 || n2 !== 0) begin
            failed++;
            $display("FAIL s0_seq got %0d%0d n2=%0d exp 10 n2=0",
                     seq_log[1], seq_log[2], n2);
        end
        tests++;
        if (done_cyc !== 3 || res_at_done !== 8'h7F) begin
            failed++;
            $display("FAIL s0_done got cyc %0d res %h exp cyc 3 res 7f",
                     done_cyc, res_at_done);
        end
    endtask

    task automatic test_shift3_busy_start();
        run_op(8'h81, 3'd3, 1'b1, 1'b0, 0, 2);
        tests++;
        if (seq_log[1] !== 3'd1 || seq_log[2] !== 3'd2 || seq_log[3] !== 3'd2
            || seq_log[4] !== 3'd2 || seq_log[5] !== 3'd0) begin
            failed++;
            $display("FAIL s3_seq got %0d%0d%0d%0d%0d exp 12220",
                     seq_log[1], seq_log[2], seq_log[3], seq_log[4], seq_log[5]);
        end
        tests++;
        if (done_cyc !== 6 || n_done !== 1) begin
            failed++;
            $display("FAIL s3_done got cyc %0d n %0d exp cyc 6 n 1",
                     done_cyc, n_done);
        end
        tests++;
        if (res_at_done !== 8'h0F) begin
            failed++;
            $display("FAIL s3_result got %h exp 0f", res_at_done);
        end
    endtask

    task automatic test_abort_shift();
        run_op(8'hAA, 3'd7, 1'b0, 1'b0, 3, 0);
        tests++;
        if (seq_log[3] !== 3'd2 || seq_log[4] !== 3'd3 || seq_log[5] !== 3'd0) begin
            failed++;
            $display("FAIL ab_seq got %0d%0d%0d exp 230",
                     seq_log[3], seq_log[4], seq_log[5]);
        end
        tests++;
        if (n_done !== 0 || busy_log[5] !== 1'b0) begin
            failed++;
            $display("FAIL ab_done got n %0d busy %b exp n 0 busy 0",
                     n_done, busy_log[5]);
        end
        tests++;
        if (result !== 8'h0F) begin
            failed++;
            $display("FAIL ab_result got %h exp 0f", result);
        end
    endtask

    task automatic test_abort_capt();
        run_op(8'h5A, 3'd0, 1'b0, 1'b0, 2, 0);
        tests++;
        if (done_cyc !== 3 || res_at_done !== 8'h5A) begin
            failed++;
            $display("FAIL abcapt got cyc %0d res %h exp cyc 3 res 5a",
                     done_cyc, res_at_done);
        end
    endtask

    task automatic test_back_to_back();
        start   = 1'b1;
        data_in = 8'h3C;
        shamt   = 3'd0;
        fill    = 1'b0;
        abort   = 1'b0;
`ifdef REGDEC_CTRL_ROTATE_EN
        rotate  = 1'b0;
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        tests++;
        if (done !== 1'b1 || result !== 8'h3C || ready !== 1'b1) begin
            failed++;
            $display("FAIL b2b_first got done %b res %h rdy %b exp 1 3c 1",
                     done, result, ready);
        end
        start   = 1'b1;
        data_in = 8'hC3;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if (seq !== 3'd1 || done !== 1'b0) begin
            failed++;
            $display("FAIL b2b_accept got seq %0d done %b exp 1 0", seq, done);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1 || result !== 8'hC3) begin
            failed++;
            $display("FAIL b2b_second got done %b res %h exp 1 c3", done, result);
        end
    endtask

    task automatic test_reset_midop();
        start   = 1'b1;
        data_in = 8'hF0;
        shamt   = 3'd7;
        fill    = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        abort = 1'b0;
        tests++;
        if (seq !== 3'd0 || busy !== 1'b0 || ready !== 1'b1 || result !== 8'h00) begin
            failed++;
            $display("FAIL rst_mid got seq %0d busy %b rdy %b res %h exp 0 0 1 00",
                     seq, busy, ready, result);
        end
    endtask

`ifdef REGDEC_CTRL_ROTATE_EN
    task automatic test_rotate();
        run_op(8'h81, 3'd1, 1'b0, 1'b1, 0, 0);
        tests++;
        if (done_cyc !== 4 || res_at_done !== 8'h03) begin
            failed++;
            $display("FAIL rot1 got cyc %0d res %h exp 4 03", done_cyc, res_at_done);
        end
        run_op(8'h81, 3'd1, 1'b0, 1'b0, 0, 0);
        tests++;
        if (done_cyc !== 4 || res_at_done !== 8'h02) begin
            failed++;
            $display("FAIL rot0 got cyc %0d res %h exp 4 02", done_cyc, res_at_done);
        end
    endtask
`endif

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_shift1();
        test_shift0();
        test_shift3_busy_start();
        test_abort_shift();
        test_abort_capt();
        test_back_to_back();
        test_reset_midop();
`ifdef REGDEC_CTRL_ROTATE_EN
        test_rotate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
